spi_command_sequencer: RTL and testbench

- Sits between the CSR/CPU bus and one genericSPI engine, and is the only block that drives that engine's strobe and command word.
- Shares the engine between two requesters: direct CPU transfers, and an autonomous sequencer that walks a local command table. The table holds AFE power-up/configuration scripts with SPI transfers, delays and an end marker.
- Serialises all traffic, enforces the engine's busy handshake, and reports read-back data and errors.

---
 rtl/spi_seq_pkg.sv | 21 ++
 rtl/spi_seq_table.sv | 17 +
 rtl/spi_command_sequencer.sv | 164 ++++++++++++++++
 tb/tb_spi_command_sequencer.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_seq_pkg.sv
// spi_seq_pkg: opcodes, status bit positions and FSM encoding shared by the SPI command sequencer
package spi_seq_pkg;
  localparam logic [1:0] OP_XFER  = 2'b00;
  localparam logic [1:0] OP_DELAY = 2'b01;
  localparam logic [1:0] OP_END   = 2'b10;
  localparam int ST_BUSY     = 31;
  localparam int ST_RUN      = 30;
  localparam int ST_CPU_PEND = 29;
  localparam int ST_OVERRUN  = 28;
  localparam int ST_TIMEOUT  = 27;
  localparam int ST_DONE     = 26;
  localparam logic [3:0] S_IDLE       = 4'd0;
  localparam logic [3:0] S_ARB        = 4'd1;
  localparam logic [3:0] S_FETCH      = 4'd2;
  localparam logic [3:0] S_ISSUE      = 4'd3;
  localparam logic [3:0] S_WAIT_START = 4'd4;
  localparam logic [3:0] S_WAIT_DONE  = 4'd5;
  localparam logic [3:0] S_DELAY      = 4'd6;
  localparam logic [3:0] S_END        = 4'd7;
  localparam logic [3:0] S_ERROR      = 4'd8;
endpackage

// File: rtl/spi_seq_table.sv
// spi_seq_table: simple dual-port command table, synchronous write and registered read
module spi_seq_table #(
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [31:0]           wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [31:0]           rd_data
);
  logic [31:0] mem [2**ADDR_WIDTH];
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end
endmodule

// File: rtl/spi_command_sequencer.sv
// spi_command_sequencer: shares one SPI engine between direct CPU transfers and a table-driven script
module spi_command_sequencer
  import spi_seq_pkg::*;
#(
  parameter int    ADDR_WIDTH    = 6,
  parameter int    START_TIMEOUT = 8,
  parameter int    XFER_TIMEOUT  = 4096,
  parameter string DEBUG         = "false"
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cpuStrobe,
  input  logic [31:0]           cpuCommand,
  input  logic                  tableWrStrobe,
  input  logic [ADDR_WIDTH-1:0] tableWrAddr,
  input  logic [31:0]           tableWrData,
  input  logic                  seqStart,
  input  logic                  seqAbort,
  input  logic                  clrErrors,
  (* mark_debug = DEBUG *) output logic spiStrobe,
  output logic [31:0]           spiCommand,
  (* mark_debug = DEBUG *) input logic [31:0] spiStatus,
  output logic [31:0]           status,
  output logic [23:0]           readData
);
  localparam int TW = $clog2((XFER_TIMEOUT > START_TIMEOUT ? XFER_TIMEOUT : START_TIMEOUT) + 1);
  (* mark_debug = DEBUG *) logic [3:0] state;
  logic cpu_pending, cpu_overrun, timeout_err, seq_done, seq_running, abort_pend, from_cpu, yield_seq;
  logic [31:0] cpu_cmd, entry;
  logic [ADDR_WIDTH-1:0] seq_ptr;
  logic [23:0] dly;
  logic [TW-1:0] timer;
  logic abort_now, seq_ok, cpu_win, cpu_clear, ovr_set, err_set, advance, ptr_last, busy, unused_status;
  spi_seq_table #(.ADDR_WIDTH(ADDR_WIDTH)) u_table (
    .clk(clk), .wr_en(tableWrStrobe), .wr_addr(tableWrAddr), .wr_data(tableWrData),
    .rd_addr(seq_ptr), .rd_data(entry)
  );
  assign abort_now = abort_pend | seqAbort;
  assign seq_ok    = seq_running & ~abort_now;
  // after a CPU grant during a running script the sequencer gets the next turn
  assign cpu_win   = cpu_pending & ~(yield_seq & seq_ok);
  assign cpu_clear = (state == S_ARB && cpu_win) || state == S_ERROR;
  assign ovr_set   = cpuStrobe & cpu_pending & ~cpu_clear;
  assign err_set   = (state == S_WAIT_START && !spiStatus[31] && timer == TW'(START_TIMEOUT - 1)) ||
                     (state == S_WAIT_DONE && spiStatus[31] && timer == TW'(XFER_TIMEOUT - 1));
  assign advance   = (state == S_DELAY && dly == 24'd1) || (state == S_WAIT_DONE && !spiStatus[31] && !from_cpu);
  assign ptr_last  = seq_ptr == {ADDR_WIDTH{1'b1}};
  assign busy      = (state != S_IDLE) | cpu_pending;
  assign unused_status = &{1'b0, spiStatus[30:24]};
  always_comb begin
    status = '0;
    status[ST_BUSY] = busy;
    status[ST_RUN] = seq_running;
    status[ST_CPU_PEND] = cpu_pending;
    status[ST_OVERRUN] = cpu_overrun;
    status[ST_TIMEOUT] = timeout_err;
    status[ST_DONE] = seq_done;
    status[23:16] = 8'(seq_ptr);
    status[15:0] = readData[15:0];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      spiStrobe <= 1'b0;
      spiCommand <= '0;
      readData <= '0;
      cpu_pending <= 1'b0;
      cpu_overrun <= 1'b0;
      timeout_err <= 1'b0;
      seq_done <= 1'b0;
      seq_running <= 1'b0;
      abort_pend <= 1'b0;
      from_cpu <= 1'b0;
      yield_seq <= 1'b0;
      cpu_cmd <= '0;
      seq_ptr <= '0;
      dly <= '0;
      timer <= '0;
    end else begin
      spiStrobe <= 1'b0;
      cpu_overrun <= ovr_set | (cpu_overrun & ~clrErrors);
      timeout_err <= err_set | (timeout_err & ~clrErrors);
      if (cpu_clear) cpu_pending <= 1'b0;
      if (cpuStrobe && !ovr_set) begin
        cpu_pending <= 1'b1;
        cpu_cmd <= cpuCommand;
      end
      if (seqAbort && seq_running) abort_pend <= 1'b1;
      if (advance) begin
        if (ptr_last) begin
          seq_running <= 1'b0;
          seq_done <= 1'b1;
        end else seq_ptr <= seq_ptr + 1'b1;
      end
      case (state)
        S_IDLE: if (cpu_pending || seq_running) state <= S_ARB;
        S_ARB: begin
          if (abort_now) begin
            seq_running <= 1'b0;
            abort_pend <= 1'b0;
          end
          if (cpu_win) begin
            spiCommand <= cpu_cmd;
            spiStrobe <= 1'b1;
            from_cpu <= 1'b1;
            yield_seq <= seq_ok;
            state <= S_ISSUE;
          end else if (seq_ok) begin
            from_cpu <= 1'b0;
            yield_seq <= 1'b0;
            state <= S_FETCH;
          end else state <= S_IDLE;
        end
        S_FETCH: begin
          if (entry[29:28] == OP_XFER) begin
            spiCommand <= {entry[31:30], 2'b00, entry[27:0]};
            spiStrobe <= 1'b1;
            state <= S_ISSUE;
          end else if (entry[29:28] == OP_DELAY) begin
            dly <= (entry[23:0] == 24'd0) ? 24'd1 : entry[23:0];
            state <= S_DELAY;
          end else state <= S_END;
        end
        S_ISSUE: begin
          timer <= '0;
          state <= S_WAIT_START;
        end
        S_WAIT_START: begin
          if (spiStatus[31]) begin
            timer <= '0;
            state <= S_WAIT_DONE;
          end else if (err_set) state <= S_ERROR;
          else timer <= timer + 1'b1;
        end
        S_WAIT_DONE: begin
          if (!spiStatus[31]) begin
            readData <= spiStatus[23:0];
            state <= (cpu_pending || seq_running) ? S_ARB : S_IDLE;
          end else if (err_set) state <= S_ERROR;
          else timer <= timer + 1'b1;
        end
        S_DELAY: if (dly == 24'd1) state <= S_ARB; else dly <= dly - 1'b1;
        S_END: begin
          seq_running <= 1'b0;
          seq_done <= 1'b1;
          abort_pend <= 1'b0;
          state <= S_ARB;
        end
        S_ERROR: begin
          seq_running <= 1'b0;
          abort_pend <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
      if (seqStart && !seq_running) begin
        seq_ptr <= '0;
        seq_running <= 1'b1;
        seq_done <= 1'b0;
        abort_pend <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_spi_command_sequencer.sv
// tb_spi_command_sequencer: scoreboard bench with a simple SPI engine model
module tb_spi_command_sequencer;
  import spi_seq_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cpuStrobe = 1'b0;
  logic [31:0] cpuCommand = '0;
  logic tableWrStrobe = 1'b0;
  logic [5:0] tableWrAddr = '0;
  logic [31:0] tableWrData = '0;
  logic seqStart = 1'b0, seqAbort = 1'b0, clrErrors = 1'b0;
  logic spiStrobe;
  logic [31:0] spiCommand;
  logic [31:0] spiStatus = '0;
  logic [31:0] status;
  logic [23:0] readData;
  int total = 0, bad = 0, cyc = 0, strobe_n = 0;
  int eng_lat = 50;
  bit eng_never = 1'b0;
  logic [23:0] eng_data = 24'h001234;
  logic [31:0] exp_q[$];
  int idle_q[$];
  int strobe_q[$];

  spi_command_sequencer dut (
    .clk(clk), .rst_n(rst_n), .cpuStrobe(cpuStrobe), .cpuCommand(cpuCommand),
    .tableWrStrobe(tableWrStrobe), .tableWrAddr(tableWrAddr), .tableWrData(tableWrData),
    .seqStart(seqStart), .seqAbort(seqAbort), .clrErrors(clrErrors),
    .spiStrobe(spiStrobe), .spiCommand(spiCommand), .spiStatus(spiStatus),
    .status(status), .readData(readData)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && spiStrobe) begin
      strobe_n++;
      strobe_q.push_back(cyc);
      if (exp_q.size() == 0) check("strobe_unexpected", 32'(exp_q.size()), 32'd1);
      else check("strobe_cmd", spiCommand, exp_q.pop_front());
    end
  end

  // engine: busy one clock after the strobe, idle eng_lat clocks later with eng_data
  always begin
    @(negedge clk);
    if (rst_n && spiStrobe && !eng_never) begin
      @(posedge clk);
      #1 spiStatus = 32'h8000_0000;
      repeat (eng_lat) @(posedge clk);
      #1 spiStatus = {8'h00, eng_data};
      idle_q.push_back(cyc);
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input logic [31:0] d);
    tableWrStrobe = 1'b1;
    tableWrAddr = 6'(a);
    tableWrData = d;
    tick();
    tableWrStrobe = 1'b0;
  endtask

  task automatic cpu(input logic [31:0] c);
    cpuCommand = c;
    cpuStrobe = 1'b1;
    tick();
    cpuStrobe = 1'b0;
  endtask

  task automatic start_seq();
    seqStart = 1'b1;
    tick();
    seqStart = 1'b0;
  endtask

  task automatic wait_strobe(input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!spiStrobe && n < 200);
    check(tag, 32'(spiStrobe), 32'd1);
  endtask

  task automatic wait_bit(input int idx, input logic val, input int max, input string tag);
    int n = 0;
    while (status[idx] !== val && n < max) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(status[idx]), 32'(val));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    tick(3);
    check("rst_status", status, 32'h0);
    check("rst_read", 32'(readData), 32'h0);
    check("rst_strobe", 32'(spiStrobe), 32'h0);
    check("rst_cmd", spiCommand, 32'h0);
    rst_n = 1'b1;
    tick();
    // direct CPU transfer
    exp_q.push_back(32'h8200_A55A);
    n0 = strobe_n;
    cpu(32'h8200_A55A);
    wait_bit(ST_BUSY, 1'b0, 200, "cpu_idle");
    check("cpu_busy_drop", 32'(cyc - (idle_q.size() > 0 ? idle_q[idle_q.size()-1] : 0)), 32'd1);
    tick();
    check("cpu_read", 32'(readData), 32'h0000_1234);
    check("cpu_strobes", 32'(strobe_n - n0), 32'd1);
    check("cpu_status_rd", 32'(status[15:0]), 32'h1234);
    // script with a delay between two transfers
    eng_lat = 10;
    eng_data = 24'h00BEEF;
    wr(0, 32'h0100_00FF);
    wr(1, {2'b00, OP_DELAY, 28'd100});
    wr(2, 32'h8300_0001);
    wr(3, {2'b00, OP_END, 28'd0});
    exp_q.push_back(32'h0100_00FF);
    exp_q.push_back(32'h8300_0001);
    n0 = strobe_n;
    start_seq();
    wait_bit(ST_RUN, 1'b0, 1000, "scr_run");
    wait_bit(ST_BUSY, 1'b0, 100, "scr_idle");
    tick();
    check("scr_strobes", 32'(strobe_n - n0), 32'd2);
    check("scr_done", 32'(status[ST_DONE]), 32'd1);
    check("scr_ptr", 32'(status[23:16]), 32'd3);
    check("scr_gap_ge100", 32'((strobe_q.size() >= 2 && idle_q.size() >= 2) ?
          (strobe_q[strobe_q.size()-1] - idle_q[idle_q.size()-2] >= 100) : 0), 32'd1);
    check("scr_read", 32'(readData), 32'h0000_BEEF);
    // CPU request interleaved into a running script
    for (int i = 0; i < 4; i++) wr(i, 32'h0100_0010 + 32'(i));
    wr(4, {2'b00, OP_END, 28'd0});
    exp_q.push_back(32'h0100_0010);
    exp_q.push_back(32'h0200_0077);
    exp_q.push_back(32'h0100_0011);
    exp_q.push_back(32'h0100_0012);
    exp_q.push_back(32'h0100_0013);
    n0 = strobe_n;
    start_seq();
    wait_strobe("il_s0");
    tick(2);
    cpu(32'h0200_0077);
    wait_bit(ST_RUN, 1'b0, 2000, "il_run");
    wait_bit(ST_BUSY, 1'b0, 100, "il_idle");
    tick();
    check("il_strobes", 32'(strobe_n - n0), 32'd5);
    check("il_q_empty", 32'(exp_q.size()), 32'd0);
    check("il_ptr", 32'(status[23:16]), 32'd4);
    // overrun while the engine is busy
    eng_lat = 30;
    exp_q.push_back(32'h0300_0001);
    exp_q.push_back(32'h0300_0002);
    n0 = strobe_n;
    cpu(32'h0300_0001);
    wait_strobe("ov_s0");
    tick(3);
    cpu(32'h0300_0002);
    cpu(32'h0300_0003);
    check("ov_pending", 32'(status[ST_CPU_PEND]), 32'd1);
    check("ov_flag", 32'(status[ST_OVERRUN]), 32'd1);
    wait_bit(ST_BUSY, 1'b0, 300, "ov_idle");
    tick();
    check("ov_strobes", 32'(strobe_n - n0), 32'd2);
    check("ov_sticky", 32'(status[ST_OVERRUN]), 32'd1);
    clrErrors = 1'b1;
    tick();
    clrErrors = 1'b0;
    check("ov_clr", 32'(status[ST_OVERRUN]), 32'd0);
    // engine never goes busy
    eng_never = 1'b1;
    wr(0, 32'h0100_00AA);
    wr(1, {2'b00, OP_END, 28'd0});
    exp_q.push_back(32'h0100_00AA);
    start_seq();
    wait_strobe("to_s0");
    repeat (8) @(negedge clk);
    check("to_early", 32'(status[ST_TIMEOUT]), 32'd0);
    @(negedge clk);
    check("to_set", 32'(status[ST_TIMEOUT]), 32'd1);
    @(negedge clk);
    check("to_run", 32'(status[ST_RUN]), 32'd0);
    check("to_idle", 32'(status[ST_BUSY]), 32'd0);
    check("to_done", 32'(status[ST_DONE]), 32'd0);
    tick();
    clrErrors = 1'b1;
    tick();
    clrErrors = 1'b0;
    check("to_clr", 32'(status[ST_TIMEOUT]), 32'd0);
    eng_never = 1'b0;
    // abort during a long delay
    eng_lat = 10;
    wr(0, 32'h0100_0055);
    wr(1, {2'b00, OP_DELAY, 28'd1000});
    wr(2, 32'h0100_0066);
    wr(3, {2'b00, OP_END, 28'd0});
    exp_q.push_back(32'h0100_0055);
    n0 = strobe_n;
    start_seq();
    wait_strobe("ab_s0");
    tick(40);
    seqAbort = 1'b1;
    tick();
    seqAbort = 1'b0;
    wait_bit(ST_BUSY, 1'b0, 1200, "ab_idle");
    tick(20);
    check("ab_strobes", 32'(strobe_n - n0), 32'd1);
    check("ab_run", 32'(status[ST_RUN]), 32'd0);
    check("ab_done", 32'(status[ST_DONE]), 32'd0);
    // reset in the middle of a transfer
    eng_lat = 50;
    eng_data = 24'h005A5A;
    exp_q.push_back(32'h0400_0042);
    cpu(32'h0400_0042);
    wait_strobe("rs_s0");
    tick(5);
    rst_n = 1'b0;
    #1;
    check("rs_strobe", 32'(spiStrobe), 32'd0);
    check("rs_cmd", spiCommand, 32'd0);
    check("rs_read", 32'(readData), 32'd0);
    check("rs_status", status, 32'd0);
    tick();
    rst_n = 1'b1;
    tick(70);
    check("rs_after", status, 32'd0);
    check("q_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
